// File: rtl/sdram_port_arbiter_if.sv
// Bundles the refill port, data port and SDRAM command/return signals around the arbiter.
// master = arbiter view; slave = requesters plus SDRAM controller.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 21
);
  logic              ic_ren;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_ack;
  logic [31:0]       ic_rdata;
  logic              d_ren;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_wmask;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [4:0]        mem_len;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              mem_wdone;
  logic              busy;

  modport master (
    input  ic_ren, ic_addr, d_ren, d_wen, d_addr, d_wdata, d_wmask,
    input  mem_cmd_ready, mem_rvalid, mem_rdata, mem_wdone,
    output ic_ack, ic_rdata, d_ack, d_rdata,
    output mem_cmd_valid, mem_we, mem_addr, mem_len, mem_wdata, mem_wmask, busy
  );

  modport slave (
    output ic_ren, ic_addr, d_ren, d_wen, d_addr, d_wdata, d_wmask,
    output mem_cmd_ready, mem_rvalid, mem_rdata, mem_wdone,
    input  ic_ack, ic_rdata, d_ack, d_rdata,
    input  mem_cmd_valid, mem_we, mem_addr, mem_len, mem_wdata, mem_wmask, busy
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Round-robin share of one SDRAM command port between I-cache line refills and single data accesses.
// Grant to command takes one cycle; the command is held stable until mem_cmd_ready, acks pass straight through.
module sdram_port_arbiter #(
  parameter int ADDR_W    = 21,
  parameter int BURST_LEN = 16
) (
  input  logic                 sdram_clk,
  input  logic                 reset,
  sdram_port_arbiter_if.master bus
);

  localparam int                CNT_W      = $clog2(BURST_LEN);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(BURST_LEN - 1);
  localparam logic              OWN_I      = 1'b0;
  localparam logic              OWN_D      = 1'b1;

  typedef enum logic [2:0] {IDLE, CMD, IBURST, DREAD, DWRITE} state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wmask_q, wmask_d;
  logic [4:0]        len_q, len_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic              d_req, grant_i, grant_d;
  logic              ic_ack, d_ack;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    wmask_d      = wmask_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    ic_ack       = 1'b0;
    d_ack        = 1'b0;
    d_req        = bus.d_ren | bus.d_wen;
    grant_i      = 1'b0;
    grant_d      = 1'b0;

    case (state_q)
      IDLE: begin
        // On a tie the side that did not win last time goes first.
        grant_i = bus.ic_ren && (!d_req || (last_grant_q == OWN_D));
        grant_d = d_req && !grant_i;
        if (grant_i) begin
          owner_d = OWN_I;
          addr_d  = bus.ic_addr & ALIGN_MASK;
          we_d    = 1'b0;
          wdata_d = '0;
          wmask_d = '0;
          len_d   = 5'(BURST_LEN);
          state_d = CMD;
        end else if (grant_d) begin
          owner_d = OWN_D;
          addr_d  = bus.d_addr;
          we_d    = bus.d_wen;
          wdata_d = bus.d_wdata;
          wmask_d = bus.d_wmask;
          len_d   = 5'd1;
          state_d = CMD;
        end
      end
      CMD: begin
        if (bus.mem_cmd_ready) begin
          last_grant_d = owner_q;
          if (owner_q == OWN_I) state_d = IBURST;
          else if (we_q)        state_d = DWRITE;
          else                  state_d = DREAD;
        end
      end
      IBURST: begin
        if (bus.mem_rvalid) begin
          ic_ack = 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
      DREAD: begin
        if (bus.mem_rvalid) begin
          d_ack   = 1'b1;
          state_d = IDLE;
        end
      end
      DWRITE: begin
        if (bus.mem_wdone) begin
          d_ack   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // An aborting reset must not let a return word through in the same cycle.
    if (reset) begin
      ic_ack = 1'b0;
      d_ack  = 1'b0;
    end
  end

  always_ff @(posedge sdram_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= OWN_D;
      owner_q      <= OWN_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      len_q        <= '0;
      word_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign bus.ic_ack        = ic_ack;
  assign bus.ic_rdata      = ic_ack ? bus.mem_rdata : 32'd0;
  assign bus.d_ack         = d_ack;
  assign bus.d_rdata       = (d_ack && !we_q) ? bus.mem_rdata : 32'd0;
  assign bus.mem_cmd_valid = (state_q == CMD);
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_len       = len_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.mem_wmask     = wmask_q;
  assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, then random traffic against a transaction-level model.
module tb_sdram_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sdram_port_arbiter_if #(.ADDR_W(21)) bus ();

  sdram_port_arbiter #(.ADDR_W(21), .BURST_LEN(16)) dut (
    .sdram_clk (clk),
    .reset     (reset),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: owner 0=none 1=instr 2=data, command pending flag, words still owed.
  int          m_owner;
  bit          m_pend;
  int          m_left;
  bit          m_prefer_i;
  logic [20:0] m_addr;
  logic        m_we;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic [4:0]  m_len;
  bit          ic_done, d_done;

  typedef struct {
    logic        ic_ren;
    logic        d_ren;
    logic        d_wen;
    logic [20:0] ic_addr;
    logic [20:0] d_addr;
    logic        exp_we;
    logic [20:0] exp_addr;
    logic [4:0]  exp_len;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Called with inputs set at posedge+1; compares at posedge+2, advances model, returns at next posedge+1.
  task automatic step();
    logic        e_valid, e_ic_ack, e_d_ack, dreq;
    logic [31:0] e_ic_rd, e_d_rd;
    #1;
    e_valid  = (m_owner != 0) && m_pend;
    e_ic_ack = !reset && (m_owner == 1) && !m_pend && bus.mem_rvalid;
    e_d_ack  = !reset && (m_owner == 2) && !m_pend && (m_we ? bus.mem_wdone : bus.mem_rvalid);
    e_ic_rd  = e_ic_ack ? bus.mem_rdata : 32'd0;
    e_d_rd   = (e_d_ack && !m_we) ? bus.mem_rdata : 32'd0;
    chk("busy", 64'(bus.busy), 64'(m_owner != 0));
    chk("cmd_valid", 64'(bus.mem_cmd_valid), 64'(e_valid));
    chk("ic_ack", 64'(bus.ic_ack), 64'(e_ic_ack));
    chk("ic_rdata", 64'(bus.ic_rdata), 64'(e_ic_rd));
    chk("d_ack", 64'(bus.d_ack), 64'(e_d_ack));
    chk("d_rdata", 64'(bus.d_rdata), 64'(e_d_rd));
    if (e_valid) begin
      chk("cmd_addr", 64'(bus.mem_addr), 64'(m_addr));
      chk("cmd_len", 64'(bus.mem_len), 64'(m_len));
      chk("cmd_we", 64'(bus.mem_we), 64'(m_we));
      if (m_we) begin
        chk("cmd_wdata", 64'(bus.mem_wdata), 64'(m_wdata));
        chk("cmd_wmask", 64'(bus.mem_wmask), 64'(m_wmask));
      end
    end
    ic_done = 0;
    d_done  = 0;
    if (reset) begin
      m_owner = 0; m_pend = 0; m_left = 0; m_prefer_i = 1;
      m_addr = '0; m_we = 0; m_wdata = '0; m_wmask = '0; m_len = '0;
    end else if (m_owner == 0) begin
      dreq = bus.d_ren | bus.d_wen;
      if (bus.ic_ren && (!dreq || m_prefer_i)) begin
        m_owner = 1;
        m_addr  = 21'((int'(bus.ic_addr) / 16) * 16);
        m_len   = 5'd16; m_we = 0; m_wdata = '0; m_wmask = '0;
      end else if (dreq) begin
        m_owner = 2;
        m_addr  = bus.d_addr; m_len = 5'd1; m_we = bus.d_wen;
        m_wdata = bus.d_wdata; m_wmask = bus.d_wmask;
      end
      m_pend = (m_owner != 0);
      m_left = int'(m_len);
    end else if (m_pend) begin
      if (bus.mem_cmd_ready) begin
        m_pend     = 0;
        m_prefer_i = (m_owner == 2);
      end
    end else if (e_ic_ack || e_d_ack) begin
      m_left--;
      if (m_left == 0) begin
        if (m_owner == 1) ic_done = 1;
        else d_done = 1;
        m_owner = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ic_ren = 0; bus.ic_addr = '0; bus.d_ren = 0; bus.d_wen = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_wmask = '0; bus.mem_cmd_ready = 0; bus.mem_rvalid = 0;
    bus.mem_rdata = '0; bus.mem_wdone = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    step();
    step();
    reset = 0;
  endtask

  task automatic check_all_zero(input string tag);
    #1;
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_valid"}, 64'(bus.mem_cmd_valid), 64'(0));
    chk({tag, "_addr"}, 64'(bus.mem_addr), 64'(0));
    chk({tag, "_len"}, 64'(bus.mem_len), 64'(0));
    chk({tag, "_we"}, 64'(bus.mem_we), 64'(0));
    chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'(0));
    chk({tag, "_acks"}, 64'({bus.ic_ack, bus.d_ack}), 64'(0));
    chk({tag, "_wcnt"}, 64'(dut.word_cnt_q), 64'(0));
  endtask

  initial begin
    int  w;
    bit  is_i;
    checks = 0;
    errors = 0;
    m_owner = 0; m_pend = 0; m_left = 0; m_prefer_i = 1;
    m_addr = '0; m_we = 0; m_wdata = '0; m_wmask = '0; m_len = '0;
    reset = 1;
    clear_inputs();
    @(posedge clk);
    #1;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 21'h00123, 21'h00000, 1'b0, 21'h00120, 5'd16};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 21'h00000, 21'h00055, 1'b0, 21'h00055, 5'd1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 21'h00000, 21'h1FFFFF, 1'b1, 21'h1FFFFF, 5'd1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 21'h00000, 21'h0ABCD, 1'b1, 21'h0ABCD, 5'd1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 21'h1FFFF, 21'h00007, 1'b0, 21'h1FFF0, 5'd16};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 21'h1FFFFF, 21'h00000, 1'b0, 21'h1FFFF0, 5'd16};

    do_reset();
    check_all_zero("reset");

    // Table: first grant after reset, command fields as seen in CMD.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      bus.ic_ren = vecs[i].ic_ren; bus.d_ren = vecs[i].d_ren; bus.d_wen = vecs[i].d_wen;
      bus.ic_addr = vecs[i].ic_addr; bus.d_addr = vecs[i].d_addr;
      step();
      #1;
      chk($sformatf("vec%0d_valid", i), 64'(bus.mem_cmd_valid), 64'(1));
      chk($sformatf("vec%0d_addr", i), 64'(bus.mem_addr), 64'(vecs[i].exp_addr));
      chk($sformatf("vec%0d_len", i), 64'(bus.mem_len), 64'(vecs[i].exp_len));
      chk($sformatf("vec%0d_we", i), 64'(bus.mem_we), 64'(vecs[i].exp_we));
      step();
    end

    // Lone refill of 16 words.
    do_reset();
    bus.ic_ren = 1; bus.ic_addr = 21'h00123;
    step();
    bus.mem_cmd_ready = 1;
    step();
    bus.mem_cmd_ready = 0;
    for (int k = 0; k < 16; k++) begin
      bus.mem_rvalid = 1; bus.mem_rdata = 32'(k);
      #1;
      chk("refill_ack", 64'(bus.ic_ack), 64'(1));
      chk("refill_data", 64'(bus.ic_rdata), 64'(k));
      step();
    end
    bus.mem_rvalid = 0; bus.ic_ren = 0;
    #1;
    chk("refill_end_busy", 64'(bus.busy), 64'(0));
    step();

    // Tie after reset, then sustained load: order I, D, I, D.
    do_reset();
    bus.ic_ren = 1; bus.ic_addr = 21'h00040; bus.d_ren = 1; bus.d_addr = 21'h00999;
    for (int t = 0; t < 4; t++) begin
      w = 0;
      while (!bus.mem_cmd_valid && w < 10) begin
        step();
        w++;
      end
      chk("rr_wait_timeout", 64'(w < 10), 64'(1));
      is_i = (bus.mem_len == 5'd16);
      chk($sformatf("rr_order%0d", t), 64'(is_i), 64'(t % 2 == 0));
      bus.mem_cmd_ready = 1;
      step();
      bus.mem_cmd_ready = 0;
      for (int k = 0; k < (is_i ? 16 : 1); k++) begin
        bus.mem_rvalid = 1;
        bus.mem_rdata = is_i ? 32'(k) : 32'hDEADBEEF;
        if (!is_i) begin
          #1;
          chk("rr_d_rdata", 64'(bus.d_rdata), 64'h0000_0000_DEAD_BEEF);
        end
        step();
      end
      bus.mem_rvalid = 0;
    end
    bus.ic_ren = 0; bus.d_ren = 0;
    step();

    // Write held off by 5 cycles of backpressure.
    do_reset();
    bus.d_wen = 1; bus.d_addr = 21'h1FFFFF; bus.d_wdata = 32'hA5A5A5A5; bus.d_wmask = 4'b0011;
    step();
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("wr_bp_addr", 64'(bus.mem_addr), 64'h1FFFFF);
      chk("wr_bp_wdata", 64'(bus.mem_wdata), 64'hA5A5A5A5);
      chk("wr_bp_wmask", 64'(bus.mem_wmask), 64'h3);
      chk("wr_bp_we_len", 64'({bus.mem_cmd_valid, bus.mem_we, bus.mem_len}), 64'({1'b1, 1'b1, 5'd1}));
      step();
    end
    bus.mem_cmd_ready = 1;
    step();
    bus.mem_cmd_ready = 0;
    step();
    bus.mem_wdone = 1;
    #1;
    chk("wr_ack", 64'(bus.d_ack), 64'(1));
    chk("wr_rdata", 64'(bus.d_rdata), 64'(0));
    step();
    bus.d_wen = 0;
    #1;
    chk("wr_single_ack", 64'(bus.d_ack), 64'(0));
    step();
    bus.mem_wdone = 0;

    // Spurious returns in IDLE and CMD, then a full burst must still need 16 words.
    do_reset();
    bus.mem_rvalid = 1; bus.mem_rdata = 32'h1234;
    #1;
    chk("spur_idle_acks", 64'({bus.ic_ack, bus.d_ack}), 64'(0));
    step();
    bus.ic_ren = 1; bus.ic_addr = 21'h00300;
    step();
    #1;
    chk("spur_cmd_acks", 64'({bus.ic_ack, bus.d_ack}), 64'(0));
    step();
    step();
    chk("spur_wcnt", 64'(dut.word_cnt_q), 64'(0));
    bus.mem_rvalid = 0; bus.mem_cmd_ready = 1;
    step();
    bus.mem_cmd_ready = 0; bus.mem_rvalid = 1;
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("spur_busy_before_last", 64'(bus.busy), 64'(1));
      step();
    end
    bus.mem_rvalid = 0; bus.ic_ren = 0;
    #1;
    chk("spur_busy_after_last", 64'(bus.busy), 64'(0));
    step();

    // Reset after the 7th refill word.
    do_reset();
    bus.ic_ren = 1; bus.ic_addr = 21'h00777;
    step();
    bus.mem_cmd_ready = 1;
    step();
    bus.mem_cmd_ready = 0; bus.mem_rvalid = 1;
    for (int k = 0; k < 7; k++) step();
    reset = 1;
    step();
    reset = 0; bus.ic_ren = 0;
    check_all_zero("midrst");
    step();
    step();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (!bus.ic_ren && ($urandom % 8 == 0)) begin
        bus.ic_ren = 1; bus.ic_addr = 21'($urandom);
      end
      if (!(bus.d_ren || bus.d_wen) && ($urandom % 6 == 0)) begin
        w = int'($urandom_range(1, 3));
        bus.d_ren = w[0]; bus.d_wen = w[1];
        bus.d_addr = 21'($urandom); bus.d_wdata = $urandom; bus.d_wmask = 4'($urandom);
      end
      bus.mem_cmd_ready = ($urandom % 3 != 0);
      bus.mem_rvalid = ($urandom % 2 == 0);
      bus.mem_rdata = $urandom;
      bus.mem_wdone = ($urandom % 4 == 0);
      reset = ($urandom % 500 == 0);
      step();
      if (ic_done) bus.ic_ren = 0;
      if (d_done) begin
        bus.d_ren = 0; bus.d_wen = 0;
      end
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Single-clock arbiter that shares the one SDRAM controller command port between the instruction-cache refill engine (16-word line bursts) and the data port (single-word read/write). It sits between the i_cache/data-side requesters and the SDRAM controller, all in the sdram_clk domain. It grants one requester at a time with round-robin fairness and routes returned data and acks back to the owner.

Parameters:
ADDR_W, 21, SDRAM word-address width (8 MB = 2M words)
BURST_LEN, 16, words per instruction line refill (power of two)

Ports:
sdram_clk  in  1  sole clock
reset  in  1  synchronous, active-high reset
ic_ren  in  1  instruction refill request, level, held until last ic_ack
ic_addr  in  ADDR_W  refill word address (arbiter aligns it)
ic_ack  out  1  one pulse per returned refill word
ic_rdata  out  32  refill data, valid with ic_ack
d_ren  in  1  data read request, level, held until d_ack
d_wen  in  1  data write request, level, held until d_ack
d_addr  in  ADDR_W  data word address
d_wdata  in  32  write data
d_wmask  in  4  byte enables for write
d_ack  out  1  single-cycle completion pulse
d_rdata  out  32  read data, valid with d_ack on reads
mem_cmd_valid  out  1  command to SDRAM controller
mem_cmd_ready  in  1  controller accepts command this cycle
mem_we  out  1  1 = write command
mem_addr  out  ADDR_W  command word address
mem_len  out  5  words in command (BURST_LEN or 1)
mem_wdata  out  32  write data
mem_wmask  out  4  write byte enables
mem_rvalid  in  1  one read word returned
mem_rdata  in  32  read word
mem_wdone  in  1  write completed
busy  out  1  arbiter not IDLE

Behaviour:
- Reset (synchronous, active-high): state=IDLE, last_grant=DATA (so instruction wins first tie), word_cnt=0; all outputs 0. Reset mid-transaction aborts immediately; no ack issued afterwards.
- States: IDLE, CMD, IBURST, DREAD, DWRITE.
- IDLE: sample requests. d_req = d_ren|d_wen. Only one pending -> grant it. Both pending -> grant the one not equal to last_grant. Grant latches owner, address, we, wdata, wmask, len into registers; -> CMD next cycle. No request -> stay.
- Instruction address latched as ic_addr & ~(BURST_LEN-1); mem_len=BURST_LEN. Data: mem_len=1, mem_we=d_wen (d_wen has priority if d_ren and d_wen both high).
- CMD: mem_cmd_valid=1 with latched fields, held stable until mem_cmd_ready. On ready: -> IBURST / DREAD / DWRITE; update last_grant to owner.
- IBURST: each mem_rvalid -> ic_ack=1, ic_rdata=mem_rdata same cycle (combinational pass-through), word_cnt++. mem_rvalid with word_cnt==BURST_LEN-1 -> word_cnt=0, -> IDLE.
- DREAD: mem_rvalid -> d_ack=1, d_rdata=mem_rdata same cycle, -> IDLE.
- DWRITE: mem_wdone -> d_ack=1 same cycle, -> IDLE.
- Acks never go to the non-owner; mem_rvalid/mem_wdone in IDLE or CMD ignored.
- Requester dropping its request after grant does not abort: transaction completes, acks still emitted.
- IDLE always takes at least one cycle between transactions; minimum transaction = IDLE, CMD, data state (3 cycles).
- word_cnt is log2(BURST_LEN) bits; never wraps within a burst.
- busy=1 in every state except IDLE.

Test Plan:
- Lone refill: ic_ren=1, ic_addr=0x00123 -> mem_cmd_valid with mem_addr=0x00120, mem_len=16, mem_we=0; 16 mem_rvalid pulses (data 0..15) -> exactly 16 ic_ack with matching ic_rdata, then IDLE, busy=0.
- Tie after reset: ic_ren and d_ren both rise same cycle -> instruction granted first; after its 16th word, data granted next (mem_len=1); d_ack with d_rdata=0xDEADBEEF.
- Round-robin under sustained load: both requests held for 4 transactions -> grant order I, D, I, D; no starvation.
- Write with backpressure: d_wen=1, d_addr=0x1FFFFF, d_wdata=0xA5A5A5A5, d_wmask=4'b0011, mem_cmd_ready low 5 cycles -> command fields stable all 5 cycles; mem_wdone -> single d_ack, d_rdata unchanged.
- Spurious returns: mem_rvalid pulsed while IDLE and during CMD -> no ic_ack/d_ack, word_cnt stays 0.
- Reset mid-burst: reset asserted after 7th ic_ack -> next cycle state IDLE, all outputs 0, word_cnt 0; further mem_rvalid produce no ack.
